// File: rtl/pipe_pkg.sv
// Types and widths shared by every stage register of the RV32I pipelined core.
package pipe_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam int unsigned REG_ADDR_W   = 5;
    localparam int unsigned ALU_CTRL_W   = 3;
    localparam int unsigned RESULT_SRC_W = 2;

    typedef struct packed {
        logic                    RegWrite;
        logic [RESULT_SRC_W-1:0] ResultSrc;
        logic                    MemWrite;
        logic                    Jump;
        logic                    Branch;
        logic [ALU_CTRL_W-1:0]   ALUControl;
        logic                    ALUSrc;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/decode_execute_pipe.sv
// Decode-to-execute pipeline register with valid tracking, hazard-unit stall/flush
// and saturating stall/flush event counters.
module decode_execute_pipe #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned REG_ADDR_W   = 5,
    parameter int unsigned ALU_CTRL_W   = 3,
    parameter int unsigned RESULT_SRC_W = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    StallE,
    input  logic                    FlushE,
    input  logic                    CntClr,
    input  logic                    ValidD,
    input  logic                    RegWriteD,
    input  logic                    MemWriteD,
    input  logic                    JumpD,
    input  logic                    BranchD,
    input  logic                    ALUSrcD,
    input  logic [RESULT_SRC_W-1:0] ResultSrcD,
    input  logic [ALU_CTRL_W-1:0]   ALUControlD,
    input  logic [DATA_W-1:0]       RD1D,
    input  logic [DATA_W-1:0]       RD2D,
    input  logic [DATA_W-1:0]       PCD,
    input  logic [DATA_W-1:0]       PCPlus4D,
    input  logic [DATA_W-1:0]       ExtImmD,
    input  logic [REG_ADDR_W-1:0]   RS1D,
    input  logic [REG_ADDR_W-1:0]   RS2D,
    input  logic [REG_ADDR_W-1:0]   RDD,
    output logic                    ValidE,
    output logic                    RegWriteE,
    output logic                    MemWriteE,
    output logic                    JumpE,
    output logic                    BranchE,
    output logic                    ALUSrcE,
    output logic [RESULT_SRC_W-1:0] ResultSrcE,
    output logic [ALU_CTRL_W-1:0]   ALUControlE,
    output logic [DATA_W-1:0]       RD1E,
    output logic [DATA_W-1:0]       RD2E,
    output logic [DATA_W-1:0]       PCE,
    output logic [DATA_W-1:0]       PCPlus4E,
    output logic [DATA_W-1:0]       ExtImmE,
    output logic [REG_ADDR_W-1:0]   RS1E,
    output logic [REG_ADDR_W-1:0]   RS2E,
    output logic [REG_ADDR_W-1:0]   RDE,
    output logic [CNT_W-1:0]        StallCnt,
    output logic [CNT_W-1:0]        FlushCnt
);

    import pipe_pkg::ctrl_t;
    import pipe_pkg::CTRL_BUBBLE;

    ctrl_t                  ctrl_d;
    ctrl_t                  ctrl_q;
    logic                   valid_q;
    logic [DATA_W-1:0]      rd1_q, rd2_q, pc_q, pc_plus4_q, ext_imm_q;
    logic [REG_ADDR_W-1:0]  rs1_q, rs2_q, rd_q;

    // An invalid decode slot loads as a side-effect-free instruction.
    always_comb begin
        ctrl_d            = CTRL_BUBBLE;
        ctrl_d.RegWrite   = RegWriteD & ValidD;
        ctrl_d.MemWrite   = MemWriteD & ValidD;
        ctrl_d.Jump       = JumpD & ValidD;
        ctrl_d.Branch     = BranchD & ValidD;
        ctrl_d.ResultSrc  = ResultSrcD;
        ctrl_d.ALUControl = ALUControlD;
        ctrl_d.ALUSrc     = ALUSrcD;
    end

    // Priority: reset > flush > stall > load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            ctrl_q     <= CTRL_BUBBLE;
            rd1_q      <= '0;
            rd2_q      <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            ext_imm_q  <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else if (FlushE) begin
            valid_q    <= 1'b0;
            ctrl_q     <= CTRL_BUBBLE;
            rd1_q      <= '0;
            rd2_q      <= '0;
            pc_q       <= '0;
            pc_plus4_q <= '0;
            ext_imm_q  <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else if (!StallE) begin
            valid_q    <= ValidD;
            ctrl_q     <= ctrl_d;
            rd1_q      <= RD1D;
            rd2_q      <= RD2D;
            pc_q       <= PCD;
            pc_plus4_q <= PCPlus4D;
            ext_imm_q  <= ExtImmD;
            rs1_q      <= RS1D;
            rs2_q      <= RS2D;
            rd_q       <= RDD;
        end
    end

    assign ValidE      = valid_q;
    assign RegWriteE   = ctrl_q.RegWrite;
    assign MemWriteE   = ctrl_q.MemWrite;
    assign JumpE       = ctrl_q.Jump;
    assign BranchE     = ctrl_q.Branch;
    assign ALUSrcE     = ctrl_q.ALUSrc;
    assign ResultSrcE  = ctrl_q.ResultSrc;
    assign ALUControlE = ctrl_q.ALUControl;
    assign RD1E        = rd1_q;
    assign RD2E        = rd2_q;
    assign PCE         = pc_q;
    assign PCPlus4E    = pc_plus4_q;
    assign ExtImmE     = ext_imm_q;
    assign RS1E        = rs1_q;
    assign RS2E        = rs2_q;
    assign RDE         = rd_q;

    // A stall that coincides with a flush is counted only as a flush.
    pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (StallE & ~FlushE),
        .count (StallCnt)
    );

    pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (CntClr),
        .inc   (FlushE),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Self-checking bench for decode_execute_pipe against a transaction-level reference model.
module tb_decode_execute_pipe;

    localparam int unsigned CW  = 3;
    localparam int          SAT = 7;

    typedef struct packed {
        logic        valid;
        logic        regwrite;
        logic [1:0]  resultsrc;
        logic        memwrite;
        logic        jump;
        logic        branch;
        logic [2:0]  aluctrl;
        logic        alusrc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic stall, flush, clr;
    rec_t din;
    rec_t obs;

    logic ValidD, RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD;
    logic [1:0]  ResultSrcD;
    logic [2:0]  ALUControlD;
    logic [31:0] RD1D, RD2D, PCD, PCPlus4D, ExtImmD;
    logic [4:0]  RS1D, RS2D, RDD;
    logic ValidE, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ExtImmE;
    logic [4:0]  RS1E, RS2E, RDE;
    logic [CW-1:0] StallCnt, FlushCnt;

    assign {ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
            RD1D, RD2D, PCD, PCPlus4D, ExtImmD, RS1D, RS2D, RDD} = din;
    assign obs = {ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
                  RD1E, RD2E, PCE, PCPlus4E, ExtImmE, RS1E, RS2E, RDE};

    decode_execute_pipe #(
        .DATA_W(32), .REG_ADDR_W(5), .ALU_CTRL_W(3), .RESULT_SRC_W(2), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .StallE(stall), .FlushE(flush), .CntClr(clr),
        .ValidD(ValidD), .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .PCPlus4D(PCPlus4D), .ExtImmD(ExtImmD),
        .RS1D(RS1D), .RS2D(RS2D), .RDD(RDD),
        .ValidE(ValidE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E), .ExtImmE(ExtImmE),
        .RS1E(RS1E), .RS2E(RS2E), .RDE(RDE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    rec_t exp_rec;
    int   exp_sc, exp_fc;

    function automatic rec_t rand_rec();
        logic [191:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[$bits(rec_t)-1:0];
    endfunction

    // What the execute stage should hold after loading a decode slot.
    function automatic rec_t loaded(rec_t d);
        rec_t r;
        r = d;
        if (!d.valid) begin
            r.regwrite = 1'b0;
            r.memwrite = 1'b0;
            r.jump     = 1'b0;
            r.branch   = 1'b0;
        end
        return r;
    endfunction

    function automatic int sat_inc(int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    // One clock: apply the reference rules at the edge, return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        if (clr) begin
            exp_sc = 0;
            exp_fc = 0;
        end else if (flush) begin
            exp_fc = sat_inc(exp_fc);
        end else if (stall) begin
            exp_sc = sat_inc(exp_sc);
        end
        if (flush)       exp_rec = '0;
        else if (!stall) exp_rec = loaded(din);
        @(negedge clk);
    endtask

    task automatic cmp_state(string name);
        checks++;
        if (obs !== exp_rec) begin
            failures++;
            $display("FAIL %s: E outputs got %h expected %h", name, obs, exp_rec);
        end
        checks++;
        if (StallCnt !== CW'(exp_sc) || FlushCnt !== CW'(exp_fc)) begin
            failures++;
            $display("FAIL %s: counters got stall=%0d flush=%0d expected stall=%0d flush=%0d",
                     name, StallCnt, FlushCnt, exp_sc, exp_fc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; clr = 1'b0;
        din = '1;
        #12;
        checks++;
        if (obs !== '0 || StallCnt !== '0 || FlushCnt !== '0) begin
            failures++;
            $display("FAIL reset_initial: got %h stall=%0d flush=%0d expected all zero", obs, StallCnt, FlushCnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        exp_rec = '0; exp_sc = 0; exp_fc = 0;
        tick();
        cmp_state("reset_first_load");
        stall = 1'b1; din = rand_rec(); tick();
        stall = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; din = rand_rec(); din.valid = 1'b1; tick();
        cmp_state("reset_pre");
        stall = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0 || StallCnt !== '0 || FlushCnt !== '0) begin
            failures++;
            $display("FAIL reset_async: got %h stall=%0d flush=%0d expected all zero", obs, StallCnt, FlushCnt);
        end
        exp_rec = '0; exp_sc = 0; exp_fc = 0;
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
    endtask

    task automatic test_load();
        din = '0;
        din.valid = 1'b1; din.rd1 = 32'h1234_5678; din.rs2 = 5'd7; din.rd = 5'd3; din.regwrite = 1'b1;
        tick();
        checks++;
        if (RD1E !== 32'h1234_5678 || RS2E !== 5'd7 || RDE !== 5'd3 || RegWriteE !== 1'b1 || ValidE !== 1'b1) begin
            failures++;
            $display("FAIL load_fields: got rd1=%h rs2=%0d rd=%0d rw=%b v=%b expected 12345678 7 3 1 1",
                     RD1E, RS2E, RDE, RegWriteE, ValidE);
        end
        cmp_state("load_model");
    endtask

    task automatic test_stall();
        rec_t a;
        clr = 1'b1; tick(); clr = 1'b0;
        a = rand_rec(); a.valid = 1'b1;
        din = a; tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = rand_rec();
            tick();
            checks++;
            if (obs !== loaded(a)) begin
                failures++;
                $display("FAIL stall_hold%0d: got %h expected %h", i, obs, loaded(a));
            end
        end
        checks++;
        if (StallCnt !== CW'(3)) begin
            failures++;
            $display("FAIL stall_count: got %0d expected 3", StallCnt);
        end
        stall = 1'b0;
        tick();
        cmp_state("stall_release");
    endtask

    task automatic test_flush_priority();
        clr = 1'b1; tick(); clr = 1'b0;
        din = rand_rec(); din.valid = 1'b1; din.memwrite = 1'b1; din.rd = 5'd9;
        tick();
        stall = 1'b1; flush = 1'b1; din = rand_rec();
        tick();
        checks++;
        if (ValidE !== 1'b0 || MemWriteE !== 1'b0 || RDE !== 5'd0 || FlushCnt !== CW'(1) || StallCnt !== CW'(0)) begin
            failures++;
            $display("FAIL flush_priority: got v=%b mw=%b rd=%0d fc=%0d sc=%0d expected 0 0 0 1 0",
                     ValidE, MemWriteE, RDE, FlushCnt, StallCnt);
        end
        cmp_state("flush_model");
        stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_invalid_load();
        din = rand_rec();
        din.valid = 1'b0; din.regwrite = 1'b1; din.memwrite = 1'b1; din.branch = 1'b1; din.jump = 1'b1;
        tick();
        checks++;
        if (ValidE !== 1'b0 || RegWriteE !== 1'b0 || MemWriteE !== 1'b0 || BranchE !== 1'b0 || JumpE !== 1'b0) begin
            failures++;
            $display("FAIL invalid_load: got v=%b rw=%b mw=%b br=%b j=%b expected all 0",
                     ValidE, RegWriteE, MemWriteE, BranchE, JumpE);
        end
        checks++;
        if (RD1E !== din.rd1 || RDE !== din.rd) begin
            failures++;
            $display("FAIL invalid_payload: got rd1=%h rd=%0d expected rd1=%h rd=%0d", RD1E, RDE, din.rd1, din.rd);
        end
    endtask

    task automatic test_saturation();
        clr = 1'b1; tick(); clr = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        checks++;
        if (StallCnt !== CW'(7)) begin
            failures++;
            $display("FAIL stall_saturate: got %0d expected 7", StallCnt);
        end
        clr = 1'b1;
        tick();
        checks++;
        if (StallCnt !== CW'(0)) begin
            failures++;
            $display("FAIL clear_over_inc: got %0d expected 0", StallCnt);
        end
        clr = 1'b0; stall = 1'b0; flush = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        checks++;
        if (FlushCnt !== CW'(7) || StallCnt !== CW'(0)) begin
            failures++;
            $display("FAIL flush_saturate: got fc=%0d sc=%0d expected 7 0", FlushCnt, StallCnt);
        end
        flush = 1'b0;
        cmp_state("saturation_model");
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            din   = rand_rec();
            stall = ($urandom_range(0, 99) < 35);
            flush = ($urandom_range(0, 99) < 15);
            clr   = ($urandom_range(0, 99) < 4);
            tick();
            cmp_state("random");
        end
        stall = 1'b0; flush = 1'b0; clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load();
        test_stall();
        test_flush_priority();
        test_invalid_load();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1);
    end

endmodule
